n0prime_hensel: RTL and testbench
=================================

Name: n0prime_hensel

Overview:
- Parametrised successor to the Montgomery n0' generator for the RSA decryption datapath.
- Computes n0' = -n^-1 mod 2^W, or n^-1 mod 2^W when NEG=0, directly from the odd modulus n.
- Uses bit-serial Hensel lifting: one add per cycle, no divider, no ordering constraint between p and q.
- Sits between key load and the Montgomery multiplier; the result is latched for the whole exponentiation.

Parameters:
- NW, 1024, width of modulus input n; only n[W-1:0] is used.
- W, 32, Montgomery word width; result width; legal 2..64.
- NEG, 1, 1 = output -n^-1 mod 2^W; 0 = output n^-1 mod 2^W.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- n  in  NW  modulus; sampled only on the accepting start edge.
- start  in  1  request; honoured only in IDLE.
- n0prime  out  W  result; held until the next accepted start.
- busy  out  1  high from the accepting edge until result is written.
- done  out  1  one-cycle pulse when n0prime/error are valid.
- error  out  1  set when sampled n[0]==0; held until the next accepted start.

Behaviour:
- Reset (rst_n low, async, any state): state=IDLE; n0prime=0, busy=0, done=0, error=0; internal y, t, i cleared. Reset mid-computation aborts; no done is generated.
- Registers: nl (W), y (W, inverse being built), t (W, = nl*y mod 2^W), i (ceil(log2 W) bits).
- IDLE: on edge with start=1:
  - nl <= n[W-1:0]; y <= 1; t <= n[W-1:0]; i <= 1; busy <= 1; done <= 0; error <= 0.
  - Go to ITER if n[0]==1, else ERR.
- ITER, one edge per bit, i = 1..W-1:
  - If t[i]==1: y[i] <= 1 and t <= t + (nl << i), truncated to W bits.
  - Else y and t are unchanged.
  - i <= i+1; after processing i==W-1, go to FIN.
- FIN, one edge:
  - n0prime <= NEG ? (~y + 1) : y, truncated to W.
  - done <= 1; busy <= 0; state <= IDLE.
- ERR, one edge: n0prime <= 0; error <= 1; done <= 1; busy <= 0; state <= IDLE.
- Latency, counting the accepting edge as edge 0:
  - Odd n: ITER edges 1..W-1, FIN at edge W. done high for the cycle after edge W; busy high after edges 0..W-1.
  - Even n: ERR at edge 1; done high for the cycle after edge 1.
- done is cleared on the next edge unconditionally.
- Back-to-back: state is IDLE while done is high, so start sampled on that cycle is accepted (edge W+1). That edge clears done and error.
- start while busy (ITER/FIN/ERR) is ignored; there is no queueing. Changes on n while busy have no effect.
- Invariant at the end of ITER: (nl*y) mod 2^W == 1 and y[0]==1.
- NEG with y==1 gives all-ones; there is no other special case.
- Width rules:
  - All arithmetic is mod 2^W.
  - nl << i drops bits at or above W.
  - n[NW-1:W] is ignored entirely.

Test Plan:
- W=32, NEG=1, n=3 (NW=1024), pulse start -> done in the cycle after edge 32, n0prime=0x55555555, error=0, busy high for exactly 32 cycles.
- W=32, NEG=0, n=0xFFFFFFFF -> n0prime=0xFFFFFFFF. Same n with NEG=1 -> 0x00000001. n=1 with NEG=1 -> 0xFFFFFFFF.
- W=16, NEG=1, n=2^1000+3 -> n0prime=0x5555, done in the cycle after edge 16 (upper bits ignored).
- W=32, n=0x10 -> done in the cycle after edge 1, error=1, n0prime=0. Then start with n=3 -> error cleared at the accepting edge, n0prime=0x55555555.
- Extra start pulses at edges 5 and 20 while busy -> ignored; a single done with the first result. start held high during the done cycle -> new computation accepted.
- rst_n low asynchronously at edge 10 of a run -> outputs 0 immediately with no clock. Release and start n=3 -> normal result. Random odd n, 500 runs, W=32 and W=64 -> (n0prime*n) mod 2^W == 2^W-1 when NEG=1.

Source files
------------

// File: rtl/n0prime_hensel.sv
// Montgomery n0' generator: bit-serial Hensel lifting of the inverse of the odd
// modulus low word, one conditional add per cycle.
module n0prime_hensel #(
  parameter int unsigned NW  = 1024,
  parameter int unsigned W   = 32,
  parameter int unsigned NEG = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [NW-1:0] n,
  input  logic          start,
  output logic [W-1:0]  n0prime,
  output logic          busy,
  output logic          done,
  output logic          error
);

  localparam int unsigned IW = $clog2(W);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ITER,
    S_FIN,
    S_ERR
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [W-1:0]  r_nl, w_nl_nxt;
  logic [W-1:0]  r_y, w_y_nxt;
  logic [W-1:0]  r_t, w_t_nxt;
  logic [IW-1:0] r_i, w_i_nxt;
  logic [W-1:0]  r_n0prime, w_n0prime_nxt;
  logic          r_busy, w_busy_nxt;
  logic          r_done, w_done_nxt;
  logic          r_error, w_error_nxt;

  // Only the low word of the modulus matters; the rest is ignored by design.
  logic w_n_unused;
  assign w_n_unused = ^n;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_nl      <= '0;
      r_y       <= '0;
      r_t       <= '0;
      r_i       <= '0;
      r_n0prime <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_error   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_nl      <= w_nl_nxt;
      r_y       <= w_y_nxt;
      r_t       <= w_t_nxt;
      r_i       <= w_i_nxt;
      r_n0prime <= w_n0prime_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_error   <= w_error_nxt;
    end
  end

  // Next-state and datapath update; t tracks nl*y so bit i of t decides y[i].
  always_comb begin
    w_state_nxt   = r_state;
    w_nl_nxt      = r_nl;
    w_y_nxt       = r_y;
    w_t_nxt       = r_t;
    w_i_nxt       = r_i;
    w_n0prime_nxt = r_n0prime;
    w_busy_nxt    = r_busy;
    w_done_nxt    = 1'b0;
    w_error_nxt   = r_error;

    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_nl_nxt    = n[W-1:0];
          w_y_nxt     = W'(1);
          w_t_nxt     = n[W-1:0];
          w_i_nxt     = IW'(1);
          w_busy_nxt  = 1'b1;
          w_error_nxt = 1'b0;
          w_state_nxt = n[0] ? S_ITER : S_ERR;
        end
      end
      S_ITER: begin
        if (r_t[r_i]) begin
          w_y_nxt = r_y | (W'(1) << r_i);
          w_t_nxt = r_t + (r_nl << r_i);
        end
        w_i_nxt = r_i + IW'(1);
        if (r_i == IW'(W - 1)) begin
          w_state_nxt = S_FIN;
        end
      end
      S_FIN: begin
        w_n0prime_nxt = (NEG != 0) ? (~r_y + W'(1)) : r_y;
        w_done_nxt    = 1'b1;
        w_busy_nxt    = 1'b0;
        w_state_nxt   = S_IDLE;
      end
      S_ERR: begin
        w_n0prime_nxt = '0;
        w_error_nxt   = 1'b1;
        w_done_nxt    = 1'b1;
        w_busy_nxt    = 1'b0;
        w_state_nxt   = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign n0prime = r_n0prime;
  assign busy    = r_busy;
  assign done    = r_done;
  assign error   = r_error;

endmodule

// File: tb/tb_n0prime_hensel.sv
// Bench for n0prime_hensel: four widths/polarities driven in parallel and
// compared against a Newton-iteration inverse model.
module tb_n0prime_hensel;

  localparam int unsigned NW = 1024;
  localparam int ND = 4;

  logic          clk;
  logic          rst_n;
  logic [NW-1:0] n;
  logic          start;

  logic [31:0]   o0_res, o1_res;
  logic [15:0]   o2_res;
  logic [63:0]   o3_res;
  logic [63:0]   res [ND];
  logic          bz  [ND];
  logic          dn  [ND];
  logic          er  [ND];

  int n_cmp;
  int n_bad;

  n0prime_hensel #(.NW(NW), .W(32), .NEG(1)) u_d0 (
    .clk(clk), .rst_n(rst_n), .n(n), .start(start),
    .n0prime(o0_res), .busy(bz[0]), .done(dn[0]), .error(er[0]));
  n0prime_hensel #(.NW(NW), .W(32), .NEG(0)) u_d1 (
    .clk(clk), .rst_n(rst_n), .n(n), .start(start),
    .n0prime(o1_res), .busy(bz[1]), .done(dn[1]), .error(er[1]));
  n0prime_hensel #(.NW(NW), .W(16), .NEG(1)) u_d2 (
    .clk(clk), .rst_n(rst_n), .n(n), .start(start),
    .n0prime(o2_res), .busy(bz[2]), .done(dn[2]), .error(er[2]));
  n0prime_hensel #(.NW(NW), .W(64), .NEG(1)) u_d3 (
    .clk(clk), .rst_n(rst_n), .n(n), .start(start),
    .n0prime(o3_res), .busy(bz[3]), .done(dn[3]), .error(er[3]));

  assign res[0] = 64'(o0_res);
  assign res[1] = 64'(o1_res);
  assign res[2] = 64'(o2_res);
  assign res[3] = o3_res;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int wd(input int d);
    case (d)
      2:       return 16;
      3:       return 64;
      default: return 32;
    endcase
  endfunction

  function automatic bit ng(input int d);
    return d != 1;
  endfunction

  // Inverse mod 2^w by Newton's iteration x <- x*(2 - n*x), doubling precision each step.
  function automatic logic [63:0] ref_inv(input logic [63:0] nl, input int w, input bit neg);
    logic [63:0] x;
    logic [63:0] mask;
    mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    if (nl[0] == 1'b0) return 64'd0;
    x = nl;
    for (int k = 0; k < 6; k++) x = x * (64'd2 - nl * x);
    if (neg) x = -x;
    return x & mask;
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One transaction on all instances; extra start pulses at edges xs1/xs2.
  task automatic run(input logic [NW-1:0] nv, input logic [ND-1:0] en,
                     input int xs1, input int xs2);
    int          first [ND];
    int          nbusy [ND];
    int          ndone [ND];
    logic [63:0] got   [ND];
    logic        gerr  [ND];
    bit          odd;
    odd = nv[0];
    @(negedge clk);
    n     = nv;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int d = 0; d < ND; d++) begin
      first[d] = -1;
      nbusy[d] = bz[d] ? 1 : 0;
      ndone[d] = 0;
      got[d]   = '0;
      gerr[d]  = 1'b0;
      if (en[d]) begin
        check_eq($sformatf("d%0d_err_clr_at_accept", d), 64'(er[d]), 64'd0);
        check_eq($sformatf("d%0d_done_low_at_accept", d), 64'(dn[d]), 64'd0);
      end
    end
    for (int k = 1; k <= 68; k++) begin
      @(negedge clk);
      n     = ~nv;
      start = (k == xs1) || (k == xs2);
      @(posedge clk);
      #1;
      start = 1'b0;
      for (int d = 0; d < ND; d++) begin
        if (bz[d]) nbusy[d]++;
        if (dn[d]) begin
          ndone[d]++;
          if (first[d] < 0) begin
            first[d] = k;
            got[d]   = res[d];
            gerr[d]  = er[d];
          end
        end
      end
    end
    for (int d = 0; d < ND; d++) begin
      if (en[d]) begin
        check_eq($sformatf("d%0d_done_edge", d), 64'(first[d]), odd ? 64'(wd(d)) : 64'd1);
        check_eq($sformatf("d%0d_done_count", d), 64'(ndone[d]), 64'd1);
        check_eq($sformatf("d%0d_busy_cycles", d), 64'(nbusy[d]), odd ? 64'(wd(d)) : 64'd1);
        check_eq($sformatf("d%0d_error", d), 64'(gerr[d]), odd ? 64'd0 : 64'd1);
        check_eq($sformatf("d%0d_n0prime", d), got[d], ref_inv(nv[63:0], wd(d), ng(d)));
        check_eq($sformatf("d%0d_n0prime_held", d), res[d], got[d]);
      end
    end
  endtask

  task automatic wait_done0(input int limit, output int cyc);
    cyc = 0;
    while (!dn[0] && cyc < limit) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  initial begin
    logic [NW-1:0] big;
    logic [NW-1:0] rn;
    int            cyc;
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    start = 1'b0;
    n     = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < ND; d++) begin
      check_eq($sformatf("d%0d_rst_n0prime", d), res[d], 64'd0);
      check_eq($sformatf("d%0d_rst_busy", d), 64'(bz[d]), 64'd0);
      check_eq($sformatf("d%0d_rst_done", d), 64'(dn[d]), 64'd0);
      check_eq($sformatf("d%0d_rst_error", d), 64'(er[d]), 64'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    run(NW'(3), 4'hF, -1, -1);
    check_eq("n3_w32_neg", res[0], 64'h5555_5555);
    check_eq("n3_w32_pos", res[1], 64'hAAAA_AAAB);
    check_eq("n3_w16_neg", res[2], 64'h5555);

    run(NW'(32'hFFFF_FFFF), 4'hF, -1, -1);
    check_eq("nff_w32_pos", res[1], 64'hFFFF_FFFF);
    check_eq("nff_w32_neg", res[0], 64'h1);

    run(NW'(1), 4'hF, -1, -1);
    check_eq("n1_w32_neg", res[0], 64'hFFFF_FFFF);
    check_eq("n1_w64_neg", res[3], 64'hFFFF_FFFF_FFFF_FFFF);

    big       = '0;
    big[1000] = 1'b1;
    big[1:0]  = 2'b11;
    run(big, 4'hF, -1, -1);
    check_eq("nbig_w16_neg", res[2], 64'h5555);

    run(NW'(16), 4'hF, -1, -1);
    check_eq("even_n0prime", res[0], 64'd0);
    check_eq("even_error", 64'(er[0]), 64'd1);
    run(NW'(3), 4'hF, -1, -1);
    check_eq("after_err_n0prime", res[0], 64'h5555_5555);
    check_eq("after_err_error", 64'(er[0]), 64'd0);

    // The 16-bit instance is idle by edge 20 and legitimately restarts, so it is masked.
    run(NW'(7), 4'b1011, 5, 20);

    // start held high through the done cycle is accepted on the following edge
    @(negedge clk);
    n     = NW'(3);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done0(60, cyc);
    check_eq("b2b_first_done_edge", 64'(cyc), 64'd32);
    check_eq("b2b_first_n0prime", res[0], 64'h5555_5555);
    n     = NW'(5);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check_eq("b2b_accept_busy", 64'(bz[0]), 64'd1);
    check_eq("b2b_accept_done", 64'(dn[0]), 64'd0);
    wait_done0(60, cyc);
    check_eq("b2b_second_done_edge", 64'(cyc), 64'd32);
    check_eq("b2b_second_n0prime", res[0], ref_inv(64'd5, 32, 1'b1));
    repeat (70) @(posedge clk);

    // asynchronous reset mid-computation
    @(negedge clk);
    n     = NW'(3);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < ND; d++) begin
      check_eq($sformatf("d%0d_arst_n0prime", d), res[d], 64'd0);
      check_eq($sformatf("d%0d_arst_busy", d), 64'(bz[d]), 64'd0);
      check_eq($sformatf("d%0d_arst_done", d), 64'(dn[d]), 64'd0);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check_eq("arst_no_late_done", 64'(dn[0]), 64'd0);
    check_eq("arst_no_late_busy", 64'(bz[0]), 64'd0);
    run(NW'(3), 4'hF, -1, -1);
    check_eq("arst_then_n3", res[0], 64'h5555_5555);

    for (int r = 0; r < 500; r++) begin
      for (int j = 0; j < NW / 32; j++) rn[j*32 +: 32] = $urandom;
      rn[0] = 1'b1;
      run(rn, 4'hF, -1, -1);
      check_eq("rand_prod_w32", (res[0] * rn[63:0]) & 64'hFFFF_FFFF, 64'hFFFF_FFFF);
      check_eq("rand_prod_w64", res[3] * rn[63:0], 64'hFFFF_FFFF_FFFF_FFFF);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
